inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Instruction queue directly downstream of the fetch branch-select/compress stage.
- Accepts 0–4 compressed, in-order instructions per cycle, with their prediction info and fetch exception.
- Buffers them in a circular queue and presents the 2 oldest to decode.
- Decouples 4-wide fetch from 2-wide decode. Flushed on branch repair or exception.

Parameters:
- DEPTH, 16, entries; power of 2, ≥8.
- CP_W, 32, width of the combined per-instruction checkpoint (PHT+RAS+IJTC).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- flush_i  in  1  discard all entries this cycle
- IF_valid_i  in  1  fetch group valid
- IF_instNum_i  in  3  valid instructions in group, 0..4
- IF_inst_p_i  in  128  4 instructions, slot0 in [31:0]
- IF_instBasePC_i  in  32  PC of slot0; slot k PC = base+4k
- IF_predDest_p_i  in  128  per-slot predicted target
- IF_predTake_p_i  in  4  per-slot predicted taken
- IF_predInfo_p_i  in  4*CP_W  per-slot checkpoint
- IF_hasException_i  in  1  group fetch exception
- IF_isRefill_i  in  1  TLB refill flag
- IF_ExcCode_i  in  5  exception code
- IQ_allowin_o  out  1  queue can take a full group this cycle
- ID_ready_i  in  1  decode consumes all valid output slots
- ID_valid_o  out  2  output slot valid, bit0 = oldest
- ID_inst_o  out  64  two instructions
- ID_PC_o  out  64  two PCs
- ID_predDest_o  out  64  two predicted targets
- ID_predTake_o  out  2  two predicted-taken bits
- ID_predInfo_o  out  2*CP_W  two checkpoints
- ID_hasException_o  out  2  per-slot exception
- ID_isRefill_o  out  2  per-slot refill flag
- ID_ExcCode_o  out  10  per-slot exception code

Behaviour:
- State: entry array, head pointer, tail pointer (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH+1 bits).
- Reset: head=tail=count=0; all outputs 0; IQ_allowin_o=1.
- IQ_allowin_o = (DEPTH - count) ≥ 4. Combinational from registered count only; independent of this cycle's pop.
- Push occurs when IF_valid_i && IQ_allowin_o && !flush_i.
  - Writes IF_instNum_i entries, slots 0..n-1, to tail..tail+n-1 with wrap.
  - Entry PC = IF_instBasePC_i + 4*k.
  - Exception fields are copied to every pushed entry.
  - IF_instNum_i=0 with IF_valid_i=1 pushes nothing.
  - IF_valid_i while !IQ_allowin_o is dropped; upstream must hold the group and stall.
- Output: ID_valid_o = {count≥2, count≥1}. Slots read combinationally from head and head+1 (wrap). Invalid slots drive all fields 0.
- Pop occurs when ID_ready_i && !flush_i. Removes popcount(ID_valid_o) entries.
- Same-cycle push and pop: count_next = count + pushN − popN; head and tail update independently.
- flush_i has priority over push and pop: next cycle head=tail=count=0, ID_valid_o=0. Entry contents are not cleared.
- Latency: an instruction pushed in cycle t is visible on ID_* in cycle t+1 if it lands at head/head+1. There is no bypass in the same cycle.
- Ordering: strict FIFO; no reordering across groups.
- Boundaries:
  - count = DEPTH-4: allowin=1, and a 4-push fills the queue exactly.
  - count = DEPTH-3: allowin=0 even if a pop occurs this cycle.
  - Tail and head wrap across DEPTH-1 → 0 within a single group.
  - count never exceeds DEPTH and never goes negative (assertion).
- Asynchronous reset mid-operation returns the block to the reset state immediately; no partial push is retained.

Test Plan:
1. Reset, push one group instNum=4, base=0xBFC0_0000, ID_ready=0 → next cycle ID_valid=2'b11, PCs 0xBFC00000/0xBFC00004, count=4.
2. Push 4 each cycle with ID_ready=0 → allowin drops when count=16 (DEPTH=16); fifth group dropped; contents of all 16 entries in order.
3. Pre-fill to head=14 via pushes/pops, push instNum=4 → entries at 14,15,0,1; drain with ID_ready=1 yields PC order +0,+4,+8,+12.
4. count=1, push instNum=3 and ID_ready=1 same cycle → count=3; outputs next cycle are the 3 new instructions' first two in order.
5. count=10, flush_i=1 together with IF_valid, instNum=4 → next cycle count=0, ID_valid=0, allowin=1.
6. Group with IF_hasException=1, ExcCode=0x04, isRefill=1, instNum=1 → ID_hasException_o[0]=1, ID_ExcCode_o[4:0]=0x04, ID_isRefill_o[0]=1, ID_inst_o[31:0]=0.

Source files
------------

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_queue
//  Purpose  : Circular instruction queue between the 4-wide fetch
//             branch-select/compress stage and the 2-wide decode stage.
//             Accepts 0..4 in-order instructions per cycle and presents the
//             two oldest entries to decode. Flushed on repair/exception.
//  Revision : 1.0  initial release
// ============================================================================
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int CP_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                IF_valid_i,
  input  logic [2:0]          IF_instNum_i,
  input  logic [127:0]        IF_inst_p_i,
  input  logic [31:0]         IF_instBasePC_i,
  input  logic [127:0]        IF_predDest_p_i,
  input  logic [3:0]          IF_predTake_p_i,
  input  logic [4*CP_W-1:0]   IF_predInfo_p_i,
  input  logic                IF_hasException_i,
  input  logic                IF_isRefill_i,
  input  logic [4:0]          IF_ExcCode_i,
  output logic                IQ_allowin_o,
  input  logic                ID_ready_i,
  output logic [1:0]          ID_valid_o,
  output logic [63:0]         ID_inst_o,
  output logic [63:0]         ID_PC_o,
  output logic [63:0]         ID_predDest_o,
  output logic [1:0]          ID_predTake_o,
  output logic [2*CP_W-1:0]   ID_predInfo_o,
  output logic [1:0]          ID_hasException_o,
  output logic [1:0]          ID_isRefill_o,
  output logic [9:0]          ID_ExcCode_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_GROUP     = c_CNT_W'(4);

  // Entry storage; contents are never cleared, validity comes from count.
  logic [31:0]        r_inst     [DEPTH];
  logic [31:0]        r_pc       [DEPTH];
  logic [31:0]        r_predDest [DEPTH];
  logic               r_predTake [DEPTH];
  logic [CP_W-1:0]    r_predInfo [DEPTH];
  logic               r_hasExc   [DEPTH];
  logic               r_isRefill [DEPTH];
  logic [4:0]         r_excCode  [DEPTH];

  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic               w_push;
  logic [c_CNT_W-1:0] w_pushN;
  logic [c_CNT_W-1:0] w_popN;
  logic [1:0]         w_valid;
  logic [c_PTR_W-1:0] w_wrIdx [4];
  logic [c_PTR_W-1:0] w_rdIdx [2];

  // Room for a whole group is judged on the registered count only, so a
  // pop in the same cycle never opens the gate.
  assign IQ_allowin_o = (c_DEPTH_CNT - r_count) >= c_GROUP;
  assign w_push       = IF_valid_i && IQ_allowin_o && !flush_i;
  assign w_valid      = {r_count >= c_CNT_W'(2), r_count >= c_CNT_W'(1)};
  assign ID_valid_o   = w_valid;

  // Push/pop amounts and the wrapped write/read slot indices.
  always_comb begin
    w_pushN = '0;
    w_popN  = '0;
    if (w_push) begin
      w_pushN = (IF_instNum_i > 3'd4) ? c_GROUP : c_CNT_W'(IF_instNum_i);
    end
    if (ID_ready_i && !flush_i) begin
      w_popN = w_valid[1] ? c_CNT_W'(2) : (w_valid[0] ? c_CNT_W'(1) : '0);
    end
    for (int k = 0; k < 4; k++) begin
      w_wrIdx[k] = r_tail + c_PTR_W'(k);
    end
    w_rdIdx[0] = r_head;
    w_rdIdx[1] = r_head + c_PTR_W'(1);
  end

  // Write the first pushN slots of the fetch group at tail..tail+pushN-1.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (c_CNT_W'(k) < w_pushN) begin
        r_inst[w_wrIdx[k]]     <= IF_inst_p_i[32*k +: 32];
        r_pc[w_wrIdx[k]]       <= IF_instBasePC_i + 32'(4 * k);
        r_predDest[w_wrIdx[k]] <= IF_predDest_p_i[32*k +: 32];
        r_predTake[w_wrIdx[k]] <= IF_predTake_p_i[k];
        r_predInfo[w_wrIdx[k]] <= IF_predInfo_p_i[CP_W*k +: CP_W];
        r_hasExc[w_wrIdx[k]]   <= IF_hasException_i;
        r_isRefill[w_wrIdx[k]] <= IF_isRefill_i;
        r_excCode[w_wrIdx[k]]  <= IF_ExcCode_i;
      end
    end
  end

  // Head/tail/count bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_popN[c_PTR_W-1:0];
      r_tail  <= r_tail + w_pushN[c_PTR_W-1:0];
      r_count <= r_count + w_pushN - w_popN;
    end
  end

  // Present the two oldest entries; invalid slots drive zeros.
  always_comb begin
    ID_inst_o         = '0;
    ID_PC_o           = '0;
    ID_predDest_o     = '0;
    ID_predTake_o     = '0;
    ID_predInfo_o     = '0;
    ID_hasException_o = '0;
    ID_isRefill_o     = '0;
    ID_ExcCode_o      = '0;
    for (int s = 0; s < 2; s++) begin
      if (w_valid[s]) begin
        ID_inst_o[32*s +: 32]         = r_inst[w_rdIdx[s]];
        ID_PC_o[32*s +: 32]           = r_pc[w_rdIdx[s]];
        ID_predDest_o[32*s +: 32]     = r_predDest[w_rdIdx[s]];
        ID_predTake_o[s]              = r_predTake[w_rdIdx[s]];
        ID_predInfo_o[CP_W*s +: CP_W] = r_predInfo[w_rdIdx[s]];
        ID_hasException_o[s]          = r_hasExc[w_rdIdx[s]];
        ID_isRefill_o[s]              = r_isRefill[w_rdIdx[s]];
        ID_ExcCode_o[5*s +: 5]        = r_excCode[w_rdIdx[s]];
      end
    end
  end

  // Occupancy stays within the physical queue and a pop never underflows.
  a_countBound : assert property (@(posedge clk) disable iff (!rst)
                                  (r_count <= c_DEPTH_CNT) && (w_popN <= r_count));

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_queue
//  Purpose  : Self-checking bench for inst_queue: directed vector table,
//             hand-written exception/reset sequences and random traffic
//             checked against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_queue;

  localparam int DEPTH = 16;
  localparam int CP_W  = 32;
  localparam int VW    = 1 + 2 + 64*3 + 2 + 2*CP_W + 2 + 2 + 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush_i = 1'b0;
  logic              IF_valid_i = 1'b0;
  logic [2:0]        IF_instNum_i = '0;
  logic [127:0]      IF_inst_p_i = '0;
  logic [31:0]       IF_instBasePC_i = '0;
  logic [127:0]      IF_predDest_p_i = '0;
  logic [3:0]        IF_predTake_p_i = '0;
  logic [4*CP_W-1:0] IF_predInfo_p_i = '0;
  logic              IF_hasException_i = 1'b0;
  logic              IF_isRefill_i = 1'b0;
  logic [4:0]        IF_ExcCode_i = '0;
  logic              IQ_allowin_o;
  logic              ID_ready_i = 1'b0;
  logic [1:0]        ID_valid_o;
  logic [63:0]       ID_inst_o;
  logic [63:0]       ID_PC_o;
  logic [63:0]       ID_predDest_o;
  logic [1:0]        ID_predTake_o;
  logic [2*CP_W-1:0] ID_predInfo_o;
  logic [1:0]        ID_hasException_o;
  logic [1:0]        ID_isRefill_o;
  logic [9:0]        ID_ExcCode_o;

  inst_queue #(.DEPTH(DEPTH), .CP_W(CP_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .IF_valid_i(IF_valid_i), .IF_instNum_i(IF_instNum_i), .IF_inst_p_i(IF_inst_p_i),
    .IF_instBasePC_i(IF_instBasePC_i), .IF_predDest_p_i(IF_predDest_p_i),
    .IF_predTake_p_i(IF_predTake_p_i), .IF_predInfo_p_i(IF_predInfo_p_i),
    .IF_hasException_i(IF_hasException_i), .IF_isRefill_i(IF_isRefill_i),
    .IF_ExcCode_i(IF_ExcCode_i), .IQ_allowin_o(IQ_allowin_o), .ID_ready_i(ID_ready_i),
    .ID_valid_o(ID_valid_o), .ID_inst_o(ID_inst_o), .ID_PC_o(ID_PC_o),
    .ID_predDest_o(ID_predDest_o), .ID_predTake_o(ID_predTake_o),
    .ID_predInfo_o(ID_predInfo_o), .ID_hasException_o(ID_hasException_o),
    .ID_isRefill_o(ID_isRefill_o), .ID_ExcCode_o(ID_ExcCode_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain FIFO of instruction records.
  typedef struct {
    logic [31:0]     inst;
    logic [31:0]     pc;
    logic [31:0]     dest;
    logic            take;
    logic [CP_W-1:0] info;
    logic            exc;
    logic            refill;
    logic [4:0]      code;
  } ent_t;
  ent_t mq[$];

  // Directed vector: inputs for one cycle plus outputs expected in that cycle.
  typedef struct {
    bit          v;
    int          n;
    logic [31:0] base;
    bit          rdy;
    bit          fl;
    logic        ea;
    logic [1:0]  ev;
    logic [31:0] p0;
    logic [31:0] p1;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] dutVec();
    return {IQ_allowin_o, ID_valid_o, ID_inst_o, ID_PC_o, ID_predDest_o, ID_predTake_o,
            ID_predInfo_o, ID_hasException_o, ID_isRefill_o, ID_ExcCode_o};
  endfunction

  // Expected output bundle derived from the model's two oldest records.
  task automatic checkModel(input string name);
    logic [1:0] ev = '0; logic [63:0] ei = '0, ep = '0, ed = '0; logic [1:0] et = '0;
    logic [2*CP_W-1:0] eInfo = '0; logic [1:0] ex = '0, er = '0; logic [9:0] ec = '0;
    logic ea;
    for (int s = 0; s < 2; s++) begin
      if (s < mq.size()) begin
        ev[s] = 1'b1;
        ei[32*s +: 32] = mq[s].inst;
        ep[32*s +: 32] = mq[s].pc;
        ed[32*s +: 32] = mq[s].dest;
        et[s] = mq[s].take;
        eInfo[CP_W*s +: CP_W] = mq[s].info;
        ex[s] = mq[s].exc;
        er[s] = mq[s].refill;
        ec[5*s +: 5] = mq[s].code;
      end
    end
    ea = (DEPTH - mq.size()) >= 4;
    chk(name, dutVec(), {ea, ev, ei, ep, ed, et, eInfo, ex, er, ec});
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelUpdate();
    int  np;
    bit  room;
    room = (DEPTH - mq.size()) >= 4;
    if (flush_i) begin
      mq.delete();
    end else begin
      np = ID_ready_i ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
      repeat (np) void'(mq.pop_front());
      if (IF_valid_i && room) begin
        for (int k = 0; k < int'(IF_instNum_i); k++) begin
          ent_t e;
          e.inst   = IF_inst_p_i[32*k +: 32];
          e.pc     = IF_instBasePC_i + 32'(4*k);
          e.dest   = IF_predDest_p_i[32*k +: 32];
          e.take   = IF_predTake_p_i[k];
          e.info   = IF_predInfo_p_i[CP_W*k +: CP_W];
          e.exc    = IF_hasException_i;
          e.refill = IF_isRefill_i;
          e.code   = IF_ExcCode_i;
          mq.push_back(e);
        end
      end
    end
  endtask

  // One cycle: drive at negedge, check against model, clock, update model.
  task automatic step(input bit v, input int n, input logic [31:0] base, input bit rdy,
                      input bit fl, input bit exc, input bit refill, input logic [4:0] code);
    IF_valid_i        = v;
    IF_instNum_i      = 3'(n);
    IF_instBasePC_i   = base;
    ID_ready_i        = rdy;
    flush_i           = fl;
    IF_hasException_i = exc;
    IF_isRefill_i     = refill;
    IF_ExcCode_i      = code;
    for (int k = 0; k < 4; k++) begin
      IF_inst_p_i[32*k +: 32]      = exc ? 32'h0 : ((base + 32'(4*k)) ^ 32'h5A00_0013);
      IF_predDest_p_i[32*k +: 32]  = $urandom;
      IF_predTake_p_i[k]           = 1'($urandom);
      IF_predInfo_p_i[CP_W*k +: CP_W] = CP_W'($urandom);
    end
    checkModel("model");
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  function automatic void addv(bit v, int n, logic [31:0] base, bit rdy, bit fl,
                               logic ea, logic [1:0] ev, logic [31:0] p0, logic [31:0] p1);
    vec_t t;
    t.v = v; t.n = n; t.base = base; t.rdy = rdy; t.fl = fl;
    t.ea = ea; t.ev = ev; t.p0 = p0; t.p1 = p1;
    tbl.push_back(t);
  endfunction

  localparam logic [31:0] A = 32'hBFC0_0000;
  localparam logic [31:0] B = 32'h8000_0000;
  localparam logic [31:0] C = 32'h0040_0000;
  localparam logic [31:0] D = 32'h0040_1000;
  localparam logic [31:0] F = 32'h1000_0000;
  localparam logic [31:0] E = 32'h2000_0000;

  initial begin
    // Fill to 16, fifth group dropped, drain shows all 16 in order.
    addv(1, 4, A,      0, 0, 1, 2'b00, 0, 0);
    addv(1, 4, A+16,   0, 0, 1, 2'b11, A, A+4);
    addv(1, 4, A+32,   0, 0, 1, 2'b11, A, A+4);
    addv(1, 4, A+48,   0, 0, 1, 2'b11, A, A+4);
    addv(1, 4, A+64,   0, 0, 0, 2'b11, A, A+4);
    for (int i = 0; i < 8; i++)
      addv(0, 0, 0, 1, 0, (16 - 2*i) <= 12, 2'b11, A + 32'(8*i), A + 32'(8*i+4));
    addv(0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
    // count = DEPTH-3: no push even with a pop; then flush at count 10.
    addv(1, 4, B,      0, 0, 1, 2'b00, 0, 0);
    addv(1, 4, B+16,   0, 0, 1, 2'b11, B, B+4);
    addv(1, 4, B+32,   0, 0, 1, 2'b11, B, B+4);
    addv(1, 1, B+48,   0, 0, 1, 2'b11, B, B+4);
    addv(1, 4, B+64,   1, 0, 0, 2'b11, B, B+4);
    addv(1, 1, B+80,   1, 0, 1, 2'b11, B+8, B+12);
    addv(1, 4, B+96,   1, 1, 1, 2'b11, B+16, B+20);
    addv(0, 0, 0,      0, 0, 1, 2'b00, 0, 0);
    // count = 1 with push 3 and pop in the same cycle; then an empty group.
    addv(1, 1, C,      0, 0, 1, 2'b00, 0, 0);
    addv(1, 3, D,      1, 0, 1, 2'b01, C, 0);
    addv(0, 0, 0,      1, 0, 1, 2'b11, D, D+4);
    addv(1, 0, B,      1, 0, 1, 2'b01, D+8, 0);
    addv(0, 0, 0,      0, 0, 1, 2'b00, 0, 0);
    // Move head/tail to 14, then a group wraps across DEPTH-1 -> 0.
    addv(0, 0, 0,      0, 1, 1, 2'b00, 0, 0);
    addv(1, 4, F,      0, 0, 1, 2'b00, 0, 0);
    addv(1, 4, F+16,   0, 0, 1, 2'b11, F, F+4);
    addv(1, 4, F+32,   0, 0, 1, 2'b11, F, F+4);
    addv(1, 2, F+48,   0, 0, 1, 2'b11, F, F+4);
    for (int i = 0; i < 7; i++)
      addv(0, 0, 0, 1, 0, (14 - 2*i) <= 12, 2'b11, F + 32'(8*i), F + 32'(8*i+4));
    addv(1, 4, E,      0, 0, 1, 2'b00, 0, 0);
    addv(0, 0, 0,      1, 0, 1, 2'b11, E, E+4);
    addv(0, 0, 0,      1, 0, 1, 2'b11, E+8, E+12);
    addv(0, 0, 0,      0, 0, 1, 2'b00, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", dutVec(), {1'b1, {(VW-1){1'b0}}});
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      chk($sformatf("vec%0d", i), VW'({IQ_allowin_o, ID_valid_o, ID_PC_o}),
          VW'({tbl[i].ea, tbl[i].ev, tbl[i].p1, tbl[i].p0}));
      step(tbl[i].v, tbl[i].n, tbl[i].base, tbl[i].rdy, tbl[i].fl, 0, 0, 5'd0);
    end

    // Exception group: fields copied to the single pushed entry.
    step(1, 1, 32'h0000_3000, 0, 0, 1, 1, 5'h04);
    chk("exc_fields", VW'({ID_valid_o, ID_hasException_o, ID_isRefill_o, ID_ExcCode_o, ID_inst_o[31:0]}),
        VW'({2'b01, 2'b01, 2'b01, 10'h004, 32'h0}));
    step(0, 0, 0, 1, 0, 0, 0, 5'd0);

    // Asynchronous reset while a push is being offered.
    step(1, 4, 32'h0000_5000, 0, 0, 0, 0, 5'd0);
    IF_valid_i = 1'b1; IF_instNum_i = 3'd4;
    #2 rst = 1'b0;
    #1 chk("async_reset", dutVec(), {1'b1, {(VW-1){1'b0}}});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    step(0, 0, 0, 0, 0, 0, 0, 5'd0);

    // Random traffic against the model; ready bias alternates to reach full.
    for (int i = 0; i < 600; i++) begin
      bit rdy;
      rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom & 32'hFFFF_FFFC,
           rdy, $urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0,
           1'($urandom), 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
